bp_be_fe_queue_buffer: RTL and testbench
========================================

// Module: bp_be_fe_queue_buffer
// PURPOSE
// - Buffers FE fetch packets (fe_queue) between the FE top and the BE issue/scheduler.
// - Entries are read speculatively and retired on commit. Roll replays uncommitted reads; clear flushes everything.
// - Applies backpressure to the FE through fe_queue_ready_and_o (valid/ready-and handshake).
// PARAMETERS
// - bp_params_p  e_bp_default_cfg  processor config; supplies fe_queue_width_lp through bp_core_if widths
// - els_p        8                 entry count; must be a power of 2 and >= 2
// - ptr_width_lp (local)           $clog2(els_p)+1; the MSB is the wrap bit
// PORTS
// - clk_i                 in   1                  single clock
// - reset_i               in   1                  asynchronous, active-high reset
// - fe_queue_i            in   fe_queue_width_lp  packet from FE
// - fe_queue_v_i          in   1                  FE packet valid
// - fe_queue_ready_and_o  out  1                  buffer can accept a packet (enq = v_i & ready_and_o)
// - fe_queue_o            out  fe_queue_width_lp  packet at the speculative read pointer
// - fe_queue_v_o          out  1                  fe_queue_o is valid
// - deq_v_i               in   1                  consumer takes fe_queue_o; ignored unless fe_queue_v_o
// - cmt_v_i               in   1                  retire the oldest read-but-uncommitted entry
// - roll_v_i              in   1                  rewind the speculative read pointer to the commit point
// - clr_v_i               in   1                  discard all entries
// - empty_o               out  1                  no entries held (wptr == cptr)
// BEHAVIOUR
// - Pointers: wptr (write), rptr (speculative read), cptr (commit). All are ptr_width_lp wide and wrap modulo 2*els_p.
// - Invariant: cptr <= rptr <= wptr (mod arithmetic). Occupancy = wptr - cptr, range 0..els_p.
// - Reset (asynchronous assert):
//   - wptr = rptr = cptr = 0.
//   - fe_queue_v_o = 0, fe_queue_ready_and_o = 1, empty_o = 1.
//   - Entry storage is not reset.
// - full = (wptr[msb] != cptr[msb]) & (wptr[lsbs] == cptr[lsbs]).
// - fe_queue_ready_and_o = ~full. It is purely registered state and never depends on same-cycle deq/cmt.
// - fe_queue_v_o = (rptr != wptr). fe_queue_o = mem[rptr[lsbs]], read combinationally from the storage.
// - Latency: there is no bypass. A packet enqueued in cycle N appears on fe_queue_o no earlier than cycle N+1.
// - Enqueue: enq writes mem[wptr], then wptr++.
// - Commit: cmt_v_i advances cptr++.
//   - Legal only when cptr != rptr, or when a deq happens in the same cycle.
//   - An illegal commit is ignored and flagged by assertion.
// - Next-state priority, evaluated each cycle:
//   - clr_v_i: wptr = rptr = cptr = cptr_n. A same-cycle enq is dropped, with no write. deq and roll are ignored.
//   - roll_v_i: rptr = cptr_n. A same-cycle deq is ignored. A same-cycle enq is accepted.
//   - otherwise: rptr += deq (only when fe_queue_v_o).
//   - cptr_n = cptr + (cmt legal). Commit is honored together with clr and roll.
// - Boundary cases:
//   - full & deq: no enq this cycle. ready_and rises the cycle after cptr advances, not after rptr.
//   - empty & deq: ignored, no pointer change.
//   - wrap: when lsbs go from els_p-1 to 0 the wrap bit toggles. full/empty stay correct across any number of wraps.
//   - roll with rptr == cptr: no-op.
//   - reset asserted mid-operation: all pointers clear immediately (asynchronously). Any in-flight enq is lost.
// - Assertions:
//   - els_p is a power of 2.
//   - no enq when full (handshake guarantees this).
//   - no cmt beyond rptr.
// STRUCTURE
// - No new package typedefs. Packet type and width come from bp_core_if (declare_bp_core_if); pointer width is a local param.
// - One sub-module: bsg_mem_1r1w
//   - width fe_queue_width_lp, els_p entries, asynchronous read.
//   - read_write_same_addr_p = 0: a write to rptr's slot cannot occur while that slot is valid.
// - Pointer registers: asynchronous-reset flops inside this module, one per pointer.
// TESTING
// - Fill: 8 enqueues back-to-back from reset.
//   - ready_and_o drops after the 8th.
//   - v_o first rises the cycle after the first enq, showing packet 0.
//   - empty_o = 0.
// - Full + commit: with 8 entries, deq 3 and commit 3.
//   - ready_and_o returns 1 the cycle after the 3rd commit.
//   - a 9th enq is stored at slot 0 with the wrap bit set.
// - Roll: enq A,B,C; deq A,B; commit A; roll.
//   - next fe_queue_o = B.
//   - deq order after roll is B, C.
//   - occupancy stays 2.
// - Clear with enq: 4 entries held; clr_v_i and enq D in the same cycle.
//   - next cycle: empty_o = 1, v_o = 0, ready_and_o = 1.
//   - D is never output.
// - Wraparound soak: 1000 random enq/deq/cmt/roll operations against a reference queue model.
//   - output order, v_o, ready_and_o and empty_o match every cycle.
// - Async reset mid-stream: assert reset_i between clock edges while holding 5 entries.
//   - outputs go to v_o = 0, ready_and_o = 1, empty_o = 1 before the next edge.

Source files
------------

// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Package for the FE->BE fetch-packet queue buffer.
// Purpose: holds the processor-configuration selector and derives the
//          fe_queue packet width from it. This slice stands in for the
//          bp_core_if width declarations, so the buffer, its interface and
//          the bench all agree on one packet width.
// Contents: e_bp_default_cfg, fe_queue_width(), fe_queue_width_lp.
package bp_be_fe_queue_buffer_pkg;

    localparam int e_bp_default_cfg = 0;

    // Maps a processor configuration to its fe_queue packet width.
    function automatic int fe_queue_width(input int cfg);
        case (cfg)
            e_bp_default_cfg: return 32;
            default:          return 64;
        endcase
    endfunction

    localparam int fe_queue_width_lp = fe_queue_width(e_bp_default_cfg);

endpackage

// File: rtl/bp_be_fe_queue_buffer_if.sv
// Interface bundling the FE-side enqueue handshake and the BE-side
// read/commit/roll/clear controls of the fe_queue buffer.
// Signal names match the buffer's port names as seen from the buffer.
// Modports:
//   slave  - the buffer itself (takes packets and controls, drives status)
//   master - the FE + BE pair driving the buffer
interface bp_be_fe_queue_buffer_if
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter int width_p = fe_queue_width_lp
);

    logic [width_p-1:0] fe_queue_i;
    logic               fe_queue_v_i;
    logic               fe_queue_ready_and_o;
    logic [width_p-1:0] fe_queue_o;
    logic               fe_queue_v_o;
    logic               deq_v_i;
    logic               cmt_v_i;
    logic               roll_v_i;
    logic               clr_v_i;
    logic               empty_o;

    modport slave (
        input  fe_queue_i, fe_queue_v_i, deq_v_i, cmt_v_i, roll_v_i, clr_v_i,
        output fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o, empty_o
    );

    modport master (
        output fe_queue_i, fe_queue_v_i, deq_v_i, cmt_v_i, roll_v_i, clr_v_i,
        input  fe_queue_ready_and_o, fe_queue_o, fe_queue_v_o, empty_o
    );

endinterface

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-file memory with asynchronous read.
// Purpose: entry storage for the fe_queue buffer. Contents are not reset.
// Ports:
//   clk_i     - write clock
//   w_v_i     - write enable
//   w_addr_i  - write slot
//   w_data_i  - write data
//   r_v_i     - the read slot currently holds live data
//   r_addr_i  - read slot
//   r_data_o  - combinational read data
module bsg_mem_1r1w #(
    parameter int width_p                = 32,
    parameter int els_p                  = 8,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp         = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // Storage array: written on the clock edge, never reset.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

    // Without same-address support the reader must never see its live slot overwritten.
    always @(posedge clk_i) begin
        assert (!(read_write_same_addr_p == 0 && w_v_i && r_v_i && (w_addr_i == r_addr_i)));
    end

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// FE->BE fetch-packet queue buffer with speculative read, commit and roll.
// Purpose: buffers fe_queue packets from the FE. The BE reads entries
//          speculatively (rptr), retires them on commit (cptr), can rewind
//          uncommitted reads with roll, and can discard everything with clr.
//          Backpressure to the FE is ~full, where full is measured against
//          the commit pointer so that read-but-uncommitted slots stay held.
// Ports:
//   clk_i    - clock
//   reset_i  - asynchronous active-high reset, clears all pointers
//   fe_be_if - slave modport: fe_queue_i/_v_i/_ready_and_o enqueue handshake,
//              fe_queue_o/_v_o read port, deq/cmt/roll/clr controls, empty_o
module bp_be_fe_queue_buffer
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter int bp_params_p = e_bp_default_cfg,
    parameter int els_p       = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_be_fe_queue_buffer_if.slave  fe_be_if
);

    localparam int width_lp      = fe_queue_width(bp_params_p);
    localparam int addr_width_lp = $clog2(els_p);
    localparam int ptr_width_lp  = addr_width_lp + 1;
    localparam bit els_ok_lp     = (els_p >= 2) && ((els_p & (els_p - 1)) == 0);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [ptr_width_lp-1:0] cptr_q, cptr_d;
    logic [ptr_width_lp-1:0] cptrCommit;
    logic                    full;
    logic                    readValid;
    logic                    enqFire;
    logic                    deqFire;
    logic                    cmtLegal;

    // Full when write and commit pointers share a slot but differ in wrap bit.
    assign full      = (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1])
                     && (wptr_q[addr_width_lp-1:0] == cptr_q[addr_width_lp-1:0]);
    assign readValid = (rptr_q != wptr_q);

    // A clear drops any same-cycle enqueue, so the write is suppressed too.
    assign enqFire  = fe_be_if.fe_queue_v_i & ~full & ~fe_be_if.clr_v_i;
    assign deqFire  = fe_be_if.deq_v_i & readValid;
    // Commit may only retire an entry already read, or one being read this cycle.
    assign cmtLegal = fe_be_if.cmt_v_i & ((rptr_q != cptr_q) | deqFire);
    assign cptrCommit = cptr_q + {{(ptr_width_lp-1){1'b0}}, cmtLegal};

    assign fe_be_if.fe_queue_ready_and_o = ~full;
    assign fe_be_if.fe_queue_v_o         = readValid;
    assign fe_be_if.empty_o              = (wptr_q == cptr_q);

    // Next-state pointers: clear beats roll beats a plain dequeue; commit applies in every case.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptrCommit;
        if (fe_be_if.clr_v_i) begin
            wptr_d = cptrCommit;
            rptr_d = cptrCommit;
        end else begin
            wptr_d = wptr_q + {{(ptr_width_lp-1){1'b0}}, enqFire};
            if (fe_be_if.roll_v_i) begin
                rptr_d = cptrCommit;
            end else begin
                rptr_d = rptr_q + {{(ptr_width_lp-1){1'b0}}, deqFire};
            end
        end
    end

    // Pointer registers, cleared asynchronously so a reset empties the queue immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    bsg_mem_1r1w #(
        .width_p                (width_lp),
        .els_p                  (els_p),
        .read_write_same_addr_p (0)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enqFire),
        .w_addr_i (wptr_q[addr_width_lp-1:0]),
        .w_data_i (fe_be_if.fe_queue_i),
        .r_v_i    (readValid),
        .r_addr_i (rptr_q[addr_width_lp-1:0]),
        .r_data_o (fe_be_if.fe_queue_o)
    );

    // Sanity checks on configuration and on the protocol the BE must follow.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (els_ok_lp);
            assert (!(enqFire && full));
            assert (!(fe_be_if.cmt_v_i && !cmtLegal));
        end
    end

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Self-checking bench for bp_be_fe_queue_buffer.
// The reference keeps the uncommitted packets in a queue (oldest first)
// plus a count of how many of them have been read speculatively.
module tb_bp_be_fe_queue_buffer;
    import bp_be_fe_queue_buffer_pkg::*;

    localparam int W   = fe_queue_width_lp;
    localparam int ELS = 8;

    logic clk;
    logic rst;

    bp_be_fe_queue_buffer_if feBeIf ();

    bp_be_fe_queue_buffer #(
        .bp_params_p (e_bp_default_cfg),
        .els_p       (ELS)
    ) dut (
        .clk_i    (clk),
        .reset_i  (rst),
        .fe_be_if (feBeIf)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    logic [W-1:0] modelQ[$];
    int           modelRead = 0;

    // Single comparison point: counts, and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, want %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic bit modelValid();
        return modelRead < modelQ.size();
    endfunction

    // Reference behaviour expressed on the queue of uncommitted packets.
    task automatic modelStep(input bit enqV, input logic [W-1:0] data, input bit deq,
                             input bit cmt, input bit roll, input bit clr);
        bit enq;
        bit deqOk;
        bit cmtOk;
        int r;
        enq   = enqV && (modelQ.size() < ELS);
        deqOk = deq && modelValid();
        cmtOk = cmt && ((modelRead > 0) || deqOk);
        if (clr) begin
            modelQ.delete();
            modelRead = 0;
        end else begin
            r = modelRead + ((!roll && deqOk) ? 1 : 0);
            if (cmtOk) begin
                void'(modelQ.pop_front());
                r--;
            end
            if (roll) r = 0;
            if (enq) modelQ.push_back(data);
            modelRead = r;
        end
    endtask

    task automatic compareModel(input string tag);
        checkOutput({tag, ".v_o"},     64'(feBeIf.fe_queue_v_o),         64'(modelValid()));
        checkOutput({tag, ".ready"},   64'(feBeIf.fe_queue_ready_and_o), 64'(modelQ.size() < ELS));
        checkOutput({tag, ".empty"},   64'(feBeIf.empty_o),              64'(modelQ.size() == 0));
        if (modelValid()) begin
            checkOutput({tag, ".data"}, 64'(feBeIf.fe_queue_o), 64'(modelQ[modelRead]));
        end
    endtask

    // Drives one cycle of inputs, advances the model on the edge, checks 1ns later.
    task automatic applyStimulus(input string tag, input bit enqV, input logic [W-1:0] data,
                                 input bit deq, input bit cmt, input bit roll, input bit clr);
        feBeIf.fe_queue_v_i = enqV;
        feBeIf.fe_queue_i   = data;
        feBeIf.deq_v_i      = deq;
        feBeIf.cmt_v_i      = cmt;
        feBeIf.roll_v_i     = roll;
        feBeIf.clr_v_i      = clr;
        @(posedge clk);
        modelStep(enqV, data, deq, cmt, roll, clr);
        #1;
        compareModel(tag);
    endtask

    task automatic idleInputs();
        feBeIf.fe_queue_v_i = 1'b0;
        feBeIf.fe_queue_i   = '0;
        feBeIf.deq_v_i      = 1'b0;
        feBeIf.cmt_v_i      = 1'b0;
        feBeIf.roll_v_i     = 1'b0;
        feBeIf.clr_v_i      = 1'b0;
    endtask

    // Pulses reset between clock edges (called just after an edge).
    task automatic pulseReset();
        idleInputs();
        #2 rst = 1'b1;
        modelQ.delete();
        modelRead = 0;
        #2 rst = 1'b0;
    endtask

    localparam logic [W-1:0] PKT_A = 32'hA0A0_0001;
    localparam logic [W-1:0] PKT_B = 32'hB0B0_0002;
    localparam logic [W-1:0] PKT_C = 32'hC0C0_0003;
    localparam logic [W-1:0] PKT_D = 32'hD0D0_0004;

    initial begin
        bit enqV;
        bit deq;
        bit cmt;
        bit roll;
        bit clr;

        rst = 1'b1;
        idleInputs();
        #12;
        compareModel("reset");
        checkOutput("reset.ready_const", 64'(feBeIf.fe_queue_ready_and_o), 64'd1);
        rst = 1'b0;

        // Fill from reset with 8 back-to-back packets.
        for (int i = 0; i < ELS; i++) begin
            applyStimulus("fill", 1'b1, W'(32'h1000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 0) begin
                checkOutput("fill.first_v", 64'(feBeIf.fe_queue_v_o), 64'd1);
                checkOutput("fill.first_pkt", 64'(feBeIf.fe_queue_o), 64'h1000);
            end
        end
        checkOutput("fill.ready_low", 64'(feBeIf.fe_queue_ready_and_o), 64'd0);
        checkOutput("fill.not_empty", 64'(feBeIf.empty_o), 64'd0);

        // Full: dequeue 3 (ready must stay low), then commit 3 (ready returns).
        for (int i = 0; i < 3; i++) applyStimulus("fulldeq", 1'b1, W'(32'hDEAD), 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fulldeq.ready_still_low", 64'(feBeIf.fe_queue_ready_and_o), 64'd0);
        for (int i = 0; i < 3; i++) applyStimulus("fullcmt", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fullcmt.ready_back", 64'(feBeIf.fe_queue_ready_and_o), 64'd1);
        applyStimulus("ninth", 1'b1, W'(32'h1008), 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ninth.wptr_wrapped", 64'(dut.wptr_q), 64'd9);
        for (int i = 0; i < 6; i++) applyStimulus("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("drain.v_low", 64'(feBeIf.fe_queue_v_o), 64'd0);

        // Roll: A,B,C in; read A,B; commit A; roll back to B.
        pulseReset();
        applyStimulus("roll.enqA", 1'b1, PKT_A, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("roll.enqB", 1'b1, PKT_B, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("roll.enqC", 1'b1, PKT_C, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("roll.deqA", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("roll.deqB", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("roll.cmtA", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("roll.roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("roll.head_is_B", 64'(feBeIf.fe_queue_o), 64'(PKT_B));
        checkOutput("roll.occupancy", 64'(modelQ.size()), 64'd2);
        applyStimulus("roll.deqB2", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("roll.then_C", 64'(feBeIf.fe_queue_o), 64'(PKT_C));
        applyStimulus("roll.deqC", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Clear with a same-cycle enqueue of D, which must never surface.
        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus("clr.fill", 1'b1, W'(32'h2000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus("clr.go", 1'b1, PKT_D, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr.empty", 64'(feBeIf.empty_o), 64'd1);
        checkOutput("clr.v_low", 64'(feBeIf.fe_queue_v_o), 64'd0);
        for (int i = 0; i < 3; i++) applyStimulus("clr.after", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random soak; commits are only issued when the BE would be allowed to.
        pulseReset();
        for (int i = 0; i < 1000; i++) begin
            enqV = ($urandom_range(0, 99) < 60);
            deq  = ($urandom_range(0, 99) < 50);
            roll = ($urandom_range(0, 99) < 5);
            clr  = ($urandom_range(0, 99) < 2);
            cmt  = ($urandom_range(0, 99) < 45) && ((modelRead > 0) || (deq && modelValid()));
            applyStimulus("soak", enqV, W'($urandom), deq, cmt, roll, clr);
        end

        // Asynchronous reset between edges while 5 entries are held.
        pulseReset();
        for (int i = 0; i < 5; i++) applyStimulus("areset.fill", 1'b1, W'(32'h3000 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        idleInputs();
        #2 rst = 1'b1;
        #1;
        checkOutput("areset.v_low", 64'(feBeIf.fe_queue_v_o), 64'd0);
        checkOutput("areset.ready_high", 64'(feBeIf.fe_queue_ready_and_o), 64'd1);
        checkOutput("areset.empty_high", 64'(feBeIf.empty_o), 64'd1);
        modelQ.delete();
        modelRead = 0;
        #1 rst = 1'b0;
        applyStimulus("areset.resume", 1'b1, W'(32'h4000), 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("areset.resume_pkt", 64'(feBeIf.fe_queue_o), 64'h4000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
